// File: rtl/enc_pkg.sv
// Shared definitions for the round-robin priority encoder.
// Mode encodings and a constant clog2 used to check the index width parameter.
package enc_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Smallest r such that 2**r >= v (returns 0 for v <= 1).
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational wrapped downward search over a request vector.
// Fixed mode searches from N-1; round-robin mode searches from start,
// then downward, wrapping from 0 to N-1. The first set bit wins.
module prio_pick
    import enc_pkg::*;
#(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    input  logic         mode,
    output logic [W-1:0] idx,
    output logic         any
);

    int s;
    int c;

    // Scan N positions downward from the effective start and keep the first hit.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no latch is inferred.
        idx = '0;
        any = 1'b0;
        s   = (mode == MODE_RR) ? int'(start) : N - 1;
        c   = 0;
        for (int k = 0; k < N; k++) begin
            c = s - k;
            if (c < 0) c = c + N;
            if (!any && req[W'(c)]) begin
                any = 1'b1;
                idx = W'(c);
            end
        end
    end

endmodule

// File: rtl/rr_priority_encoder.sv
// Registered N-to-W priority encoder for active-low requests with
// fixed or round-robin selection and a valid/ready output handshake.
// Optional macro ENC_ONEHOT_EN adds a registered one-hot grant output gnt_oh.
module rr_priority_encoder
    import enc_pkg::*;
#(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_n,
    input  logic         mode,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] y
`ifdef ENC_ONEHOT_EN
    ,
    output logic [N-1:0] gnt_oh
`endif
);

    if (W != clog2(N)) begin : g_bad_w
        $error("rr_priority_encoder: W must equal ceil(log2(N))");
    end

    localparam logic [W-1:0] PTR_RST = W'(N - 1);

    logic [N-1:0] req;
    logic         load;
    logic         hs;
    logic [W-1:0] pick_idx;
    logic         pick_any;

    logic         out_valid_q, out_valid_d;
    logic [W-1:0] y_q, y_d;
    logic [W-1:0] ptr_q, ptr_d;

    assign req  = ~req_n;
    assign load = !out_valid_q || out_ready;
    assign hs   = out_valid_q && out_ready;

    // The search starts from the pointer as it will be after this edge, so a
    // consumed index is never offered again back-to-back.
    prio_pick #(.N(N), .W(W)) u_pick (
        .req   (req),
        .start (ptr_d),
        .mode  (mode),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Next pointer tracks the consumed index in both modes; output stage loads or holds.
    always_comb begin
        ptr_d       = ptr_q;
        y_d         = y_q;
        out_valid_d = out_valid_q;
        if (hs) begin
            ptr_d = (y_q == '0) ? PTR_RST : y_q - W'(1);
        end
        if (load) begin
            out_valid_d = pick_any;
            if (pick_any) y_d = pick_idx;
        end
    end

    // Output register and pointer, asynchronously reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            y_q         <= '0;
            ptr_q       <= PTR_RST;
        end else begin
            // NOTE: state flops use non-blocking assignment so all registers update from pre-edge values.
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign y         = y_q;

`ifdef ENC_ONEHOT_EN
    logic [N-1:0] gnt_q, gnt_d;

    // One-hot of the loaded index; cleared whenever the stage loads with no request.
    always_comb begin
        gnt_d = gnt_q;
        if (load) begin
            for (int i = 0; i < N; i++) begin
                gnt_d[i] = pick_any && (pick_idx == W'(i));
            end
        end
    end

    // One-hot grant register, follows the same load/hold rules as y.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) gnt_q <= '0;
        else     gnt_q <= gnt_d;
    end

    assign gnt_oh = gnt_q;
`else
    // No one-hot register in this build.
`endif

endmodule

// File: tb/tb_rr_priority_encoder.sv
// Directed self-checking bench for rr_priority_encoder: an N=8 instance
// exercises reset, fixed, round-robin, backpressure and idle behaviour, and
// an N=5 instance exercises the non-power-of-two wrap.
module tb_rr_priority_encoder;

    logic       clk;
    logic       rst;
    logic [7:0] req_n;
    logic       mode;
    logic       out_ready;
    logic       out_valid;
    logic [2:0] y;

    logic       rst5;
    logic [4:0] req5_n;
    logic       mode5;
    logic       ready5;
    logic       valid5;
    logic [2:0] y5;

`ifdef ENC_ONEHOT_EN
    logic [7:0] gnt_oh;
    logic [4:0] gnt5_oh;
`endif

    int total;
    int passed;

    rr_priority_encoder #(.N(8), .W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_n     (req_n),
        .mode      (mode),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .y         (y)
`ifdef ENC_ONEHOT_EN
        ,
        .gnt_oh    (gnt_oh)
`endif
    );

    rr_priority_encoder #(.N(5), .W(3)) dut5 (
        .clk       (clk),
        .rst       (rst5),
        .req_n     (req5_n),
        .mode      (mode5),
        .out_ready (ready5),
        .out_valid (valid5),
        .y         (y5)
`ifdef ENC_ONEHOT_EN
        ,
        .gnt_oh    (gnt5_oh)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rr_exp [8];
        int alt_exp [4];
        int n5_exp [7];
        total     = 0;
        passed    = 0;
        rr_exp    = '{6, 5, 4, 3, 2, 1, 0, 7};
        alt_exp   = '{3, 1, 3, 1};
        n5_exp    = '{4, 3, 2, 1, 0, 4, 3};

        rst       = 1'b1;
        rst5      = 1'b1;
        req_n     = 8'hFF;
        mode      = 1'b0;
        out_ready = 1'b1;
        req5_n    = 5'h00;
        mode5     = 1'b1;
        ready5    = 1'b1;
        repeat (2) step();
        check("reset_valid", 8'(out_valid), 8'd0);
        check("reset_y", 8'(y), 8'd0);
        rst = 1'b0;

        // Idle: no requests keeps out_valid low; dropping bit 2 offers 2.
        step();
        check("idle_valid", 8'(out_valid), 8'd0);
        req_n = 8'hFB;
        step();
        check("idle_y", 8'(y), 8'd2);
        check("idle_valid_up", 8'(out_valid), 8'd1);

        // Fixed mode: requests 6, 4, 0 -> highest is 6, repeatedly.
        req_n = 8'b1010_1110;
        step();
        check("fixed_y0", 8'(y), 8'd6);
        check("fixed_valid", 8'(out_valid), 8'd1);
        step();
        check("fixed_y1", 8'(y), 8'd6);
        step();
        check("fixed_y2", 8'(y), 8'd6);

        // Switch to RR: consuming 6 leaves ptr=5, so 5 is offered next.
        mode  = 1'b1;
        req_n = 8'h00;
        step();
        check("bp_offer", 8'(y), 8'd5);

        // Backpressure: request change must not disturb the held offer.
        out_ready = 1'b0;
        req_n     = 8'h7F;
        step();
        check("bp_hold_y0", 8'(y), 8'd5);
        check("bp_hold_valid", 8'(out_valid), 8'd1);
        mode = 1'b0;
        step();
        check("bp_hold_y1", 8'(y), 8'd5);
        mode      = 1'b1;
        out_ready = 1'b1;
        step();
        check("bp_wrap", 8'(y), 8'd7);

        // Round-robin over all requests: continues 6 down to 0, then wraps to 7.
        req_n = 8'h00;
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("rr_all_%0d", i), 8'(y), 8'(rr_exp[i]));
        end

        // Only requests 3 and 1: alternate fairly.
        req_n = 8'b1111_0101;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("rr_alt_%0d", i), 8'(y), 8'(alt_exp[i]));
        end

        // Asynchronous reset mid-offer, observed before the next clock edge.
        req_n = 8'h00;
        step();
        check("pre_rst_valid", 8'(out_valid), 8'd1);
        rst = 1'b1;
        #1;
        check("async_rst_valid", 8'(out_valid), 8'd0);
        check("async_rst_y", 8'(y), 8'd0);
        step();
        rst = 1'b0;
        step();
        check("post_rst_y", 8'(y), 8'd7);
        check("post_rst_valid", 8'(out_valid), 8'd1);

        // Non-power-of-two N=5, all requests, round-robin: 4,3,2,1,0,4,...
        check("n5_reset_valid", 8'(valid5), 8'd0);
        rst5 = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            check($sformatf("n5_seq_%0d", i), 8'(y5), 8'(n5_exp[i]));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
